bitc_selftest: RTL and testbench

- Hardware stimulus/checker engine for the 2-bit magnitude comparator (`bitc`). This is the driving end of the comparator's interface.
- On `start`, it sweeps all 16 operand combinations onto the comparator inputs `a,b,c,d`, waits a settle interval, then samples `e,f,g`.
- Each sample is checked against a golden model; mismatches are counted and the first failing vector is recorded.
- Sits beside `bitc` in the board-level top as a built-in self-test.

---
 rtl/bitc_pkg.sv | 27 ++
 rtl/bitc_golden.sv | 11 +
 rtl/bitc_selftest.sv | 122 ++++++++++++
 tb/tb_bitc_selftest.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitc_pkg.sv
// Shared types, response encodings and golden model for the 2-bit comparator self-test.
package bitc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // {e,f,g} = {A>B, A==B, A<B}
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // idx = {a,b,c,d}; A = idx[3:2], B = idx[1:0], both unsigned.
  function automatic logic [2:0] cmp_expect(input logic [3:0] idx);
    logic [1:0] op_a;
    logic [1:0] op_b;
    op_a = idx[3:2];
    op_b = idx[1:0];
    if (op_a > op_b)       cmp_expect = CMP_GT;
    else if (op_a == op_b) cmp_expect = CMP_EQ;
    else                   cmp_expect = CMP_LT;
  endfunction

endpackage

// File: rtl/bitc_golden.sv
// Combinational reference: vector index to the expected comparator response {e,f,g}.
module bitc_golden
  import bitc_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [2:0] resp_o
);

  assign resp_o = cmp_expect(idx_i);

endmodule

// File: rtl/bitc_selftest.sv
// Built-in self-test for the 2-bit comparator: sweeps all 16 operand pairs, checks
// each response against the golden model, counts mismatches and keeps the first one.
module bitc_selftest
  import bitc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail,
  output logic             fail_seen,
  output state_e           dbg_state
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       ff_q, ff_d;
  logic             fs_q, fs_d;
  logic [2:0]       exp_resp;
  logic [2:0]       dut_resp;

  bitc_golden u_golden (
    .idx_i  (idx_q),
    .resp_o (exp_resp)
  );

  assign dut_resp = {e, f, g};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  // start is a level, looked at only in IDLE/DONE; busy/done are the only replies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          fs_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        // Exact 3-bit compare so non-one-hot or all-zero responses count as failures.
        if (dut_resp != exp_resp) begin
          err_d = err_q + ERR_W'(1);
          if (!fs_q) begin
            ff_d = idx_q;
            fs_d = 1'b1;
          end
        end
        if (idx_q == 4'hF) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // idx_q is held at 0 in IDLE and at 1111 in DONE, so it drives the operands directly.
  assign {a, b, c, d} = idx_q;
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign pass         = done && (err_q == '0);
  assign err_count    = err_q;
  assign first_fail   = ff_q;
  assign fail_seen    = fs_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bitc_selftest.sv
// Bench for bitc_selftest: behavioural comparators (clean, faulty, delayed) feed two
// instances; sweep results are predicted into a scoreboard and checked at done.
module tb_bitc_selftest;

  localparam int ERR_W = 5;
  localparam int RW    = ERR_W + 6;

  logic clk;
  logic rst;
  logic start0, start1;

  logic a0, b0, c0, d0, busy0, done0, pass0, fs0;
  logic [ERR_W-1:0] err0;
  logic [3:0]       ff0;
  logic [2:0]       rsp0;
  bitc_pkg::state_e st0;

  logic a1, b1, c1, d1, busy1, done1, pass1, fs1;
  logic [ERR_W-1:0] err1;
  logic [3:0]       ff1;
  logic [2:0]       rsp1, r1_q, r2_q;
  bitc_pkg::state_e st1;

  int fault0;
  int dly1;
  int total;
  int bad;

  logic [RW-1:0] exp_q[$];

  bitc_selftest #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .e(rsp0[2]), .f(rsp0[1]), .g(rsp0[0]),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .fail_seen(fs0),
    .dbg_state(st0)
  );

  bitc_selftest #(.SETTLE_CYCLES(1), .ERR_W(ERR_W)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .e(rsp1[2]), .f(rsp1[1]), .g(rsp1[0]),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_seen(fs1),
    .dbg_state(st1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparator models ----------------
  function automatic logic [2:0] ref_cmp(input logic [3:0] v);
    logic [1:0] av;
    logic [1:0] bv;
    av = v[3:2];
    bv = v[1:0];
    ref_cmp = {av > bv, av == bv, av < bv};
  endfunction

  always_comb begin
    rsp0 = ref_cmp({a0, b0, c0, d0});
    if (fault0 == 1)      rsp0 = rsp0 & 3'b101;
    else if (fault0 == 2) rsp0 = {rsp0[0], rsp0[1], rsp0[2]};
  end

  initial begin
    r1_q = 3'b000;
    r2_q = 3'b000;
  end
  always @(posedge clk) begin
    r1_q <= ref_cmp({a1, b1, c1, d1});
    r2_q <= r1_q;
  end
  assign rsp1 = (dly1 == 2) ? r2_q : r1_q;

  // Predicted {pass, fail_seen, first_fail, err_count} for a full sweep.
  // mode: 0 clean, 1 f stuck-at-0, 2 e/g swapped, 3 one-cycle delay, 4 two-cycle delay.
  function automatic logic [RW-1:0] model_result(input int mode);
    logic [ERR_W-1:0] errs;
    logic [3:0]       ffv;
    logic             fsv;
    logic [3:0]       v;
    logic [2:0]       want;
    logic [2:0]       seen;
    errs = '0;
    ffv  = '0;
    fsv  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v    = 4'(i);
      want = ref_cmp(v);
      case (mode)
        1:       seen = want & 3'b101;
        2:       seen = {want[0], want[1], want[2]};
        4:       seen = (i == 0) ? want : ref_cmp(v - 4'd1);
        default: seen = want;
      endcase
      if (seen !== want) begin
        errs = errs + 1'b1;
        if (!fsv) begin
          ffv = v;
          fsv = 1'b1;
        end
      end
    end
    return {(errs == '0), fsv, ffv, errs};
  endfunction

  // ---------------- observation helpers ----------------
  function automatic logic [3:0] obs_ops(input int sel);
    return (sel != 0) ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
  endfunction
  function automatic logic [2:0] obs_flags(input int sel);
    return (sel != 0) ? {busy1, done1, pass1} : {busy0, done0, pass0};
  endfunction
  function automatic logic [RW-1:0] obs_result(input int sel);
    return (sel != 0) ? {pass1, fs1, ff1, err1} : {pass0, fs0, ff0, err0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start1 = v;
    else          start0 = v;
  endtask

  task automatic run_sweep(input int sel, input int mode, input bit hold, input string name);
    int s1;
    int last;
    logic [RW-1:0] exp_r;
    logic [RW-1:0] got_r;
    s1 = (sel != 0) ? 2 : 3;
    last = 16 * s1;
    if (sel != 0) dly1 = (mode == 4) ? 2 : 1;
    else          fault0 = mode;
    exp_q.push_back(model_result(mode));
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    for (int t = 0; t < last; t++) begin
      total++;
      if (obs_ops(sel) !== 4'(t / s1) || obs_flags(sel) !== 3'b100) begin
        bad++;
        $display("FAIL %s step t=%0d ops=%b busy/done/pass=%b want ops=%b busy/done/pass=100",
                 name, t, obs_ops(sel), obs_flags(sel), 4'(t / s1));
      end
      @(negedge clk);
    end
    exp_r = exp_q.pop_front();
    total++;
    if (obs_flags(sel) !== {1'b0, 1'b1, exp_r[RW-1]} || obs_ops(sel) !== 4'hF) begin
      bad++;
      $display("FAIL %s done_at_%0d busy/done/pass=%b ops=%b want %b ops=1111",
               name, last, obs_flags(sel), obs_ops(sel), {1'b0, 1'b1, exp_r[RW-1]});
    end
    got_r = obs_result(sel);
    total++;
    if (got_r !== exp_r) begin
      bad++;
      $display("FAIL %s result pass=%b fail_seen=%b first_fail=%b err=%0d want pass=%b fail_seen=%b first_fail=%b err=%0d",
               name, got_r[RW-1], got_r[RW-2], got_r[RW-3 -: 4], got_r[ERR_W-1:0],
               exp_r[RW-1], exp_r[RW-2], exp_r[RW-3 -: 4], exp_r[ERR_W-1:0]);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({obs_ops(0), obs_flags(0), obs_result(0)} !== '0 || st0 !== bitc_pkg::ST_IDLE) begin
      bad++;
      $display("FAIL reset0 ops=%b flags=%b result=%b state=%0d want all zero, IDLE",
               obs_ops(0), obs_flags(0), obs_result(0), st0);
    end
    total++;
    if ({obs_ops(1), obs_flags(1), obs_result(1)} !== '0 || st1 !== bitc_pkg::ST_IDLE) begin
      bad++;
      $display("FAIL reset1 ops=%b flags=%b result=%b state=%0d want all zero, IDLE",
               obs_ops(1), obs_flags(1), obs_result(1), st1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean;
    run_sweep(0, 0, 1'b0, "clean");
  endtask

  task automatic test_f_stuck;
    run_sweep(0, 1, 1'b0, "f_stuck0");
  endtask

  task automatic test_eg_swap;
    run_sweep(0, 2, 1'b0, "eg_swap");
  endtask

  task automatic test_reset_mid;
    fault0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({obs_ops(0), obs_flags(0), obs_result(0)} !== '0 || st0 !== bitc_pkg::ST_IDLE) begin
      bad++;
      $display("FAIL reset_mid ops=%b flags=%b result=%b state=%0d want all zero, IDLE",
               obs_ops(0), obs_flags(0), obs_result(0), st0);
    end
    rst = 1'b0;
    run_sweep(0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_start_held;
    run_sweep(0, 0, 1'b1, "start_held");
    @(negedge clk);
    total++;
    if (obs_flags(0) !== 3'b100 || obs_ops(0) !== 4'h0 || st0 !== bitc_pkg::ST_SETTLE) begin
      bad++;
      $display("FAIL restart busy/done/pass=%b ops=%b state=%0d want 100 ops=0000 SETTLE",
               obs_flags(0), obs_ops(0), st0);
    end
    start0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_settle1;
    run_sweep(1, 3, 1'b0, "settle1_delay1");
    run_sweep(1, 4, 1'b0, "settle1_delay2");
  endtask

  task automatic test_back_to_back;
    run_sweep(0, 2, 1'b0, "b2b_swap");
    run_sweep(0, 0, 1'b0, "b2b_clean");
  endtask

  // ---------------- main ----------------
  initial begin
    total  = 0;
    bad    = 0;
    fault0 = 0;
    dly1   = 1;
    start0 = 1'b0;
    start1 = 1'b0;
    rst    = 1'b1;
    test_reset();
    test_clean();
    test_f_stuck();
    test_eg_swap();
    test_reset_mid();
    test_start_held();
    test_settle1();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover entries=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
